regfile_wb: RTL and testbench
=============================

REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Parameter NREG, default 16, number of 32-bit registers.
REQ-002 Parameter AW, default 4, register address width; NREG SHALL equal 2**AW.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 indata  input  32  writeback data from the writeback select mux.
REQ-006 indata_sel  input  2  writeback source tag: 00 alu, 01 dmem, 10 decoder, 11 invalid.
REQ-007 wr_en  input  1  write request for indata.
REQ-008 wr_addr  input  AW  destination register of the write.
REQ-009 pend_set  input  1  load issued; mark destination pending.
REQ-010 pend_addr  input  AW  destination register of the issued load.
REQ-011 rd_addr_a, rd_addr_b  input  AW each  read port addresses.
REQ-012 rd_data_a, rd_data_b  output  32 each  read port data.
REQ-013 stall  output  1  a read port addresses a register whose load has not returned.
REQ-014 pend_vec  output  NREG  current pending-load scoreboard.
REQ-015 err  output  1  sticky flag for an illegal write.

Function
REQ-016 Register 0 SHALL read 0 always; writes and pend_set targeting it SHALL be ignored.
REQ-017 Legal write: wr_en=1, indata_sel!=11, wr_addr!=0; mem[wr_addr] SHALL take indata at the next rising edge.
REQ-018 wr_en=1 with indata_sel=11 SHALL not write and SHALL set err at the next edge; err stays 1 until reset.
REQ-019 Reads SHALL be combinational (zero latency).
REQ-020 Bypass: when a legal write's wr_addr equals a read address in the same cycle, that port SHALL return indata, not stored data.
REQ-021 Scoreboard: pend_set=1 SHALL set pend_vec[pend_addr] at the next edge.
REQ-022 A legal write with indata_sel=01 SHALL clear pend_vec[wr_addr] at the next edge; sources 00/10 SHALL NOT clear pending bits.
REQ-023 Same-cycle set and clear of the same address: set SHALL win, because the new load is younger.
REQ-024 stall SHALL be 1 when, for either port, rd_addr!=0, pend_vec[rd_addr]=1, and there is no same-cycle dmem write to rd_addr.
REQ-025 A same-cycle dmem write to a pending rd_addr SHALL deassert stall for that port and supply indata through bypass.
REQ-026 Port A and port B may address the same register; each SHALL obey REQ-020 and REQ-024 independently.
REQ-027 When stall=1, rd_data SHALL still present the stored or bypassed value; the consumer discards it.

Reset
REQ-028 On rst_n=0, all registers, pend_vec and err SHALL clear immediately, independent of clk.
REQ-029 A write or pend_set asserted during reset SHALL have no effect.
REQ-030 At reset release, stall and both rd_data outputs SHALL be 0 until the first write.

Structure
REQ-031 Source-tag constants (SRC_ALU=00, SRC_DMEM=01, SRC_DEC=10, SRC_INV=11) SHALL live in the shared core package, alongside the writeback select mux.
REQ-032 The read path SHALL be one sub-module, regfile_rdport, instantiated twice; it contains the bypass and stall logic for one port.

Verification
REQ-033 Write 0xDEADBEEF to r5 (sel 00), then read A=5 next cycle -> rd_data_a=0xDEADBEEF, stall=0.
REQ-034 In the same cycle, write 0x12345678 to r3 and read B=3 -> rd_data_b=0x12345678 (bypass); write r0=0xFFFFFFFF -> read 0 returns 0.
REQ-035 pend_set r7, then read A=7 -> stall=1; two cycles later dmem write 0xA5A5A5A5 to r7 with read A=7 -> stall=0, data 0xA5A5A5A5; next cycle pend_vec[7]=0.
REQ-036 pend r4 pending; same cycle dmem write r4 and pend_set r4 -> pend_vec[4]=1 next cycle; alu write to r4 -> pend_vec[4] stays 1.
REQ-037 wr_en with sel=11 to r2 with 0x1 -> r2 unchanged, err=1 and held; assert rst_n=0 mid-run -> err, pend_vec and all registers 0 immediately.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared core definitions for the writeback stage: source tags and the
// writeback select mux that feeds the register file.
package regfile_wb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_DMEM = 2'b01,
        SRC_DEC  = 2'b10,
        SRC_INV  = 2'b11
    } src_e;

    function automatic logic [DATA_W-1:0] wb_select(
        input src_e              sel,
        input logic [DATA_W-1:0] alu_data,
        input logic [DATA_W-1:0] dmem_data,
        input logic [DATA_W-1:0] dec_data
    );
        logic [DATA_W-1:0] res;
        case (sel)
            SRC_ALU:  res = alu_data;
            SRC_DMEM: res = dmem_data;
            SRC_DEC:  res = dec_data;
            default:  res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Writeback/read bus between the pipeline (master) and the register file (slave).
interface regfile_wb_if #(
    parameter int NREG = 16,
    parameter int AW   = 4
);
    logic [31:0]     indata;
    logic [1:0]      indata_sel;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            pend_set;
    logic [AW-1:0]   pend_addr;
    logic [AW-1:0]   rd_addr_a;
    logic [AW-1:0]   rd_addr_b;
    logic [31:0]     rd_data_a;
    logic [31:0]     rd_data_b;
    logic            stall;
    logic [NREG-1:0] pend_vec;
    logic            err;

    modport master (
        output indata, indata_sel, wr_en, wr_addr, pend_set, pend_addr,
               rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, stall, pend_vec, err
    );

    modport slave (
        input  indata, indata_sel, wr_en, wr_addr, pend_set, pend_addr,
               rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, stall, pend_vec, err
    );
endinterface

// File: rtl/regfile_wb_rdport.sv
// One combinational read port: r0 masking, same-cycle write bypass and
// pending-load stall detection.
module regfile_rdport
    import regfile_wb_pkg::*;
#(
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic [AW-1:0]     rd_addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic [NREG-1:0]   pend_vec_i,
    input  logic              wr_legal_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  src_e              wr_sel_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              stall_o
);

    logic hit_s;
    logic dmem_hit_s;

    // Bypass selection and stall decision for this port.
    always_comb begin
        rd_data_o  = {DATA_W{1'b0}};
        stall_o    = 1'b0;
        hit_s      = wr_legal_i && (wr_addr_i == rd_addr_i);
        dmem_hit_s = hit_s && (wr_sel_i == SRC_DMEM);
        if (rd_addr_i == {AW{1'b0}}) begin
            rd_data_o = {DATA_W{1'b0}};
            stall_o   = 1'b0;
        end else if (hit_s) begin
            rd_data_o = wr_data_i;
            stall_o   = pend_vec_i[rd_addr_i] && !dmem_hit_s;
        end else begin
            rd_data_o = stored_i;
            stall_o   = pend_vec_i[rd_addr_i];
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Writeback register file: NREG x 32-bit with hardwired r0, write bypass,
// pending-load scoreboard and a sticky illegal-write flag.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_wb_if.slave bus
);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [NREG-1:0]   pend_q, pend_d;
    logic              err_q, err_d;
    src_e              wr_sel_s;
    logic              wr_legal_s;
    logic              pend_clr_s;
    logic              pend_set_s;
    logic              stall_a_s, stall_b_s;

    assign wr_sel_s = src_e'(bus.indata_sel);

    // Write qualification, scoreboard next state and sticky error.
    always_comb begin
        wr_legal_s = bus.wr_en && (wr_sel_s != SRC_INV) && (bus.wr_addr != {AW{1'b0}});
        pend_clr_s = wr_legal_s && (wr_sel_s == SRC_DMEM);
        pend_set_s = bus.pend_set && (bus.pend_addr != {AW{1'b0}});
        err_d      = err_q || (bus.wr_en && (wr_sel_s == SRC_INV));
        pend_d     = pend_q;
        // A set beats a clear on the same entry: the newly issued load is younger.
        for (int i = 0; i < NREG; i++) begin
            if (pend_set_s && (bus.pend_addr == AW'(i))) begin
                pend_d[i] = 1'b1;
            end else if (pend_clr_s && (bus.wr_addr == AW'(i))) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // Register array, scoreboard and error flag state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            pend_q <= {NREG{1'b0}};
            err_q  <= 1'b0;
        end else begin
            if (wr_legal_s) begin
                mem_q[bus.wr_addr] <= bus.indata;
            end
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    regfile_rdport #(.NREG(NREG), .AW(AW)) u_rdport_a (
        .rd_addr_i  (bus.rd_addr_a),
        .stored_i   (mem_q[bus.rd_addr_a]),
        .pend_vec_i (pend_q),
        .wr_legal_i (wr_legal_s),
        .wr_addr_i  (bus.wr_addr),
        .wr_sel_i   (wr_sel_s),
        .wr_data_i  (bus.indata),
        .rd_data_o  (bus.rd_data_a),
        .stall_o    (stall_a_s)
    );

    regfile_rdport #(.NREG(NREG), .AW(AW)) u_rdport_b (
        .rd_addr_i  (bus.rd_addr_b),
        .stored_i   (mem_q[bus.rd_addr_b]),
        .pend_vec_i (pend_q),
        .wr_legal_i (wr_legal_s),
        .wr_addr_i  (bus.wr_addr),
        .wr_sel_i   (wr_sel_s),
        .wr_data_i  (bus.indata),
        .rd_data_o  (bus.rd_data_b),
        .stall_o    (stall_b_s)
    );

    assign bus.stall    = stall_a_s || stall_b_s;
    assign bus.pend_vec = pend_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: stimulus pushes expected outputs into a
// queue; a negedge monitor pops and compares them.
module tb_regfile_wb;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        stall;
        logic [15:0] pv;
        logic        err;
    } exp_t;

    exp_t exp_q [$];

    regfile_wb_if #(.NREG(16), .AW(4)) bus ();

    regfile_wb #(.NREG(16), .AW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s got=%08h expected=%08h", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "rd_data_a", bus.rd_data_a, e.a);
            cmp(e.name, "rd_data_b", bus.rd_data_b, e.b);
            cmp(e.name, "stall", {31'd0, bus.stall}, {31'd0, e.stall});
            cmp(e.name, "pend_vec", {16'd0, bus.pend_vec}, {16'd0, e.pv});
            cmp(e.name, "err", {31'd0, bus.err}, {31'd0, e.err});
        end
    end

    task automatic step(
        input string       nm,
        input logic        chk,
        input logic        rn,
        input logic        we,
        input logic [1:0]  sel,
        input logic [3:0]  wa,
        input logic [31:0] d,
        input logic        ps,
        input logic [3:0]  pa,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [31:0] ea,
        input logic [31:0] eb,
        input logic        es,
        input logic [15:0] epv,
        input logic        ee
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = rn;
        bus.wr_en      = we;
        bus.indata_sel = sel;
        bus.wr_addr    = wa;
        bus.indata     = d;
        bus.pend_set   = ps;
        bus.pend_addr  = pa;
        bus.rd_addr_a  = ra;
        bus.rd_addr_b  = rb;
        if (chk) begin
            e.name  = nm;
            e.a     = ea;
            e.b     = eb;
            e.stall = es;
            e.pv    = epv;
            e.err   = ee;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.wr_en      = 1'b0;
        bus.indata_sel = 2'b00;
        bus.wr_addr    = 4'd0;
        bus.indata     = 32'd0;
        bus.pend_set   = 1'b0;
        bus.pend_addr  = 4'd0;
        bus.rd_addr_a  = 4'd0;
        bus.rd_addr_b  = 4'd0;
        repeat (2) @(posedge clk);

        //    name          chk  rn   we   sel    wa     data          ps   pa     ra     rb     exp_a         exp_b         st   pv        err
        step("rst_wr",      1'b0,1'b0,1'b1,2'b00,4'd1, 32'h11111111,1'b1,4'd2, 4'd1, 4'd2, 32'h0,        32'h0,        1'b0,16'h0000,1'b0);
        step("reset_idle",  1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd1, 4'd2, 32'h0,        32'h0,        1'b0,16'h0000,1'b0);
        step("wr_r5",       1'b1,1'b1,1'b1,2'b00,4'd5, 32'hDEADBEEF,1'b0,4'd0, 4'd0, 4'd0, 32'h0,        32'h0,        1'b0,16'h0000,1'b0);
        step("rd_r5",       1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd5, 4'd0, 32'hDEADBEEF, 32'h0,        1'b0,16'h0000,1'b0);
        step("byp_r3",      1'b1,1'b1,1'b1,2'b00,4'd3, 32'h12345678,1'b0,4'd0, 4'd5, 4'd3, 32'hDEADBEEF, 32'h12345678, 1'b0,16'h0000,1'b0);
        step("wr_r0",       1'b1,1'b1,1'b1,2'b00,4'd0, 32'hFFFFFFFF,1'b0,4'd0, 4'd0, 4'd3, 32'h0,        32'h12345678, 1'b0,16'h0000,1'b0);
        step("rd_r0",       1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd0, 4'd0, 32'h0,        32'h0,        1'b0,16'h0000,1'b0);
        step("pend7_issue", 1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b1,4'd7, 4'd7, 4'd0, 32'h0,        32'h0,        1'b0,16'h0000,1'b0);
        step("stall7",      1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd7, 4'd0, 32'h0,        32'h0,        1'b1,16'h0080,1'b0);
        step("stall7_hold", 1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd7, 4'd0, 32'h0,        32'h0,        1'b1,16'h0080,1'b0);
        step("dmem7_byp",   1'b1,1'b1,1'b1,2'b01,4'd7, 32'hA5A5A5A5,1'b0,4'd0, 4'd7, 4'd0, 32'hA5A5A5A5, 32'h0,        1'b0,16'h0080,1'b0);
        step("pend7_clr",   1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd7, 4'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0,16'h0000,1'b0);
        step("pend4_issue", 1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b1,4'd4, 4'd0, 4'd4, 32'h0,        32'h0,        1'b0,16'h0000,1'b0);
        step("setwin_same", 1'b1,1'b1,1'b1,2'b01,4'd4, 32'hCAFEF00D,1'b1,4'd4, 4'd4, 4'd4, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0,16'h0010,1'b0);
        step("alu_nocl",    1'b1,1'b1,1'b1,2'b00,4'd4, 32'h0BADC0DE,1'b0,4'd0, 4'd4, 4'd0, 32'h0BADC0DE, 32'h0,        1'b1,16'h0010,1'b0);
        step("alu_kept",    1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd4, 4'd5, 32'h0BADC0DE, 32'hDEADBEEF, 1'b1,16'h0010,1'b0);
        step("pend9_issue", 1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b1,4'd9, 4'd0, 4'd0, 32'h0,        32'h0,        1'b0,16'h0010,1'b0);
        step("split_port",  1'b1,1'b1,1'b1,2'b01,4'd4, 32'h44444444,1'b0,4'd0, 4'd4, 4'd9, 32'h44444444, 32'h0,        1'b1,16'h0210,1'b0);
        step("dec_nocl",    1'b1,1'b1,1'b1,2'b10,4'd9, 32'h99999999,1'b0,4'd0, 4'd4, 4'd9, 32'h44444444, 32'h99999999, 1'b1,16'h0200,1'b0);
        step("inv_wr",      1'b1,1'b1,1'b1,2'b11,4'd2, 32'h00000001,1'b0,4'd0, 4'd2, 4'd9, 32'h0,        32'h99999999, 1'b1,16'h0200,1'b0);
        step("err_set",     1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd2, 4'd0, 32'h0,        32'h0,        1'b0,16'h0200,1'b1);
        step("err_hold",    1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd3, 4'd5, 32'h12345678, 32'hDEADBEEF, 1'b0,16'h0200,1'b1);
        step("pend_r0",     1'b1,1'b1,1'b1,2'b01,4'd6, 32'h66666666,1'b1,4'd0, 4'd6, 4'd0, 32'h66666666, 32'h0,        1'b0,16'h0200,1'b1);
        step("pend_r0_ign", 1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd6, 4'd7, 32'h66666666, 32'hA5A5A5A5, 1'b0,16'h0200,1'b1);
        step("async_rst",   1'b1,1'b0,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd5, 4'd9, 32'h0,        32'h0,        1'b0,16'h0000,1'b0);
        step("post_rst",    1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd4, 4'd9, 32'h0,        32'h0,        1'b0,16'h0000,1'b0);
        step("post_rst2",   1'b1,1'b1,1'b0,2'b00,4'd0, 32'h0,       1'b0,4'd0, 4'd7, 4'd3, 32'h0,        32'h0,        1'b0,16'h0000,1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
